// File: rtl/aq_gemac_tx_arb.sv
// aq_gemac_tx_arb: two-source frame arbiter in front of the GEMAC TX frame interface.
// Source 0 (ARP responder) and source 1 (IP/ICMP echo responder) share one MAC path.
// Whole frames are granted atomically, an idle gap follows every frame, and runaway
// frames are truncated at MAX_FRAME beats with the remainder drained from the source.
// Optional build macro AQ_GEMAC_TX_ARB_PRIO_EN: fixed priority (source 0 always wins
// a tie). Without it, ties go round-robin to the source not served last.
module aq_gemac_tx_arb #(
  parameter int IFG_CYCLES = 12,
  parameter int MAX_FRAME  = 1518,
  parameter int CNT_W      = 16
) (
  input  logic             SYS_CLK,
  input  logic             RST_N,
  input  logic             S0_REQ,
  input  logic [7:0]       S0_DATA,
  input  logic             S0_VALID,
  input  logic             S0_LAST,
  output logic             S0_READY,
  output logic             S0_GNT,
  input  logic             S1_REQ,
  input  logic [7:0]       S1_DATA,
  input  logic             S1_VALID,
  input  logic             S1_LAST,
  output logic             S1_READY,
  output logic             S1_GNT,
  output logic [7:0]       TX_DATA,
  output logic             TX_VALID,
  output logic             TX_LAST,
  input  logic             TX_READY,
  output logic             TX_ABORT,
  output logic [CNT_W-1:0] FRM_CNT0,
  output logic [CNT_W-1:0] FRM_CNT1
);

  localparam int BCW = 11;
  localparam int GCW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [BCW-1:0] TRUNC_AT = BCW'(MAX_FRAME - 1);
  localparam logic [GCW-1:0] GAP_END  = GCW'(IFG_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, XFER, DROP, GAP} state_t;

  state_t           state;
  logic             sel;
  logic             gnt0;
  logic             gnt1;
  logic             abort;
  logic [BCW-1:0]   byte_cnt;
  logic [GCW-1:0]   gap_cnt;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  logic             any_req;
  logic             win;
  logic             src_valid;
  logic             src_last;
  logic             src_ready;
  logic             src_acc;
  logic             trunc_hit;
  logic             frame_end;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_last;

  assign any_req = S0_REQ | S1_REQ;

`ifdef AQ_GEMAC_TX_ARB_PRIO_EN
  // Fixed priority: source 0 wins whenever it is requesting.
  always_comb begin
    win = ~S0_REQ;
  end
`else
  logic last_ptr;

  // Round-robin: a lone requester wins, a tie goes to the source not served last.
  always_comb begin
    win = S1_REQ;
    if (S0_REQ && S1_REQ) begin
      win = ~last_ptr;
    end
  end

  // Last-served pointer; also moves on a truncated frame so a runaway source cannot starve the other.
  always_ff @(posedge SYS_CLK) begin
    if (!RST_N) begin
      last_ptr <= 1'b1;
    end else if (frame_end) begin
      last_ptr <= sel;
    end
  end
`endif

  // Pass-through datapath from the owning source; DROP swallows bytes without presenting them to TX.
  always_comb begin
    src_valid = sel ? S1_VALID : S0_VALID;
    src_last  = sel ? S1_LAST  : S0_LAST;
    trunc_hit = (byte_cnt == TRUNC_AT);
    src_ready = 1'b0;
    tx_data   = 8'h00;
    tx_valid  = 1'b0;
    tx_last   = 1'b0;
    case (state)
      XFER: begin
        src_ready = TX_READY;
        tx_data   = sel ? S1_DATA : S0_DATA;
        tx_valid  = src_valid;
        tx_last   = src_last | trunc_hit;
      end
      DROP: begin
        src_ready = 1'b1;
      end
      default: begin
      end
    endcase
    src_acc   = src_valid & src_ready;
    frame_end = src_acc & src_last & ((state == XFER) | (state == DROP));
  end

  // Frame-level FSM: arbitration, byte counting, truncation, inter-frame gap and frame counters.
  always_ff @(posedge SYS_CLK) begin
    if (!RST_N) begin
      state    <= IDLE;
      sel      <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      abort    <= 1'b0;
      byte_cnt <= '0;
      gap_cnt  <= '0;
      cnt0     <= '0;
      cnt1     <= '0;
    end else begin
      abort <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state    <= XFER;
            sel      <= win;
            gnt0     <= ~win;
            gnt1     <= win;
            byte_cnt <= '0;
          end
        end
        XFER: begin
          if (src_acc) begin
            byte_cnt <= byte_cnt + BCW'(1);
            if (frame_end) begin
              if (sel) begin
                cnt1 <= cnt1 + CNT_W'(1);
              end else begin
                cnt0 <= cnt0 + CNT_W'(1);
              end
              gnt0    <= 1'b0;
              gnt1    <= 1'b0;
              gap_cnt <= '0;
              state   <= GAP;
            end else if (trunc_hit) begin
              abort <= 1'b1;
              state <= DROP;
            end
          end
        end
        DROP: begin
          if (frame_end) begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_END) begin
            if (any_req) begin
              state    <= XFER;
              sel      <= win;
              gnt0     <= ~win;
              gnt1     <= win;
              byte_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + GCW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign S0_READY = src_ready & ~sel;
  assign S1_READY = src_ready & sel;
  assign S0_GNT   = gnt0;
  assign S1_GNT   = gnt1;
  assign TX_DATA  = tx_data;
  assign TX_VALID = tx_valid;
  assign TX_LAST  = tx_last;
  assign TX_ABORT = abort;
  assign FRM_CNT0 = cnt0;
  assign FRM_CNT1 = cnt1;

endmodule

// File: tb/tb_aq_gemac_tx_arb.sv
// tb_aq_gemac_tx_arb: table-driven bench for aq_gemac_tx_arb with MAX_FRAME=64.
// Source models stream a known byte pattern; the bench tracks grants, gaps,
// truncation and frame counts and compares them with hand-computed values.
module tb_aq_gemac_tx_arb;

  localparam int IFG  = 12;
  localparam int MAXF = 64;
  localparam int CW   = 16;

  logic          clk;
  logic          rst_n;
  logic          s0_req, s0_valid, s0_last, s0_ready, s0_gnt;
  logic [7:0]    s0_data;
  logic          s1_req, s1_valid, s1_last, s1_ready, s1_gnt;
  logic [7:0]    s1_data;
  logic [7:0]    tx_data;
  logic          tx_valid, tx_last, tx_ready, tx_abort;
  logic [CW-1:0] frm_cnt0, frm_cnt1;

  aq_gemac_tx_arb #(.IFG_CYCLES(IFG), .MAX_FRAME(MAXF), .CNT_W(CW)) dut (
    .SYS_CLK(clk), .RST_N(rst_n),
    .S0_REQ(s0_req), .S0_DATA(s0_data), .S0_VALID(s0_valid), .S0_LAST(s0_last),
    .S0_READY(s0_ready), .S0_GNT(s0_gnt),
    .S1_REQ(s1_req), .S1_DATA(s1_data), .S1_VALID(s1_valid), .S1_LAST(s1_last),
    .S1_READY(s1_ready), .S1_GNT(s1_gnt),
    .TX_DATA(tx_data), .TX_VALID(tx_valid), .TX_LAST(tx_last), .TX_READY(tx_ready),
    .TX_ABORT(tx_abort), .FRM_CNT0(frm_cnt0), .FRM_CNT1(frm_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int n0; int l0; int n1; int l1;
    int o0; int o1; int o2; int o3;
    int no; int c0; int c1;
  } vec_t;

  vec_t vecs[6];

  int total, passed;
  int cyc;
  int len[2], rem[2], pos[2], fidx[2];
  logic bp_mode;
  logic pg0, pg1;
  int order[$];
  int beats, drop_beats, data_err, rdy_err, mirror_err, abort_cnt, abort_cyc;
  int trunc_beat, trunc_cyc, last_beat_no, end_cyc, first_gnt_cyc, start_cyc;
  int gap_min, gap_max, fb;

  // Expected byte for source s, frame f, position p
  function automatic logic [7:0] pat(input int s, input int f, input int p);
    return 8'((s * 128) + (f * 7) + (p * 3));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic reset_stats();
    order.delete();
    beats = 0; drop_beats = 0; data_err = 0; rdy_err = 0; mirror_err = 0;
    abort_cnt = 0; abort_cyc = -1; trunc_beat = -1; trunc_cyc = -1;
    last_beat_no = -1; end_cyc = -1; first_gnt_cyc = -1;
    gap_min = 1000000; gap_max = -1; fb = 0;
  endtask

  // Source inputs follow the model: REQ until first beat accepted, VALID throughout the frame
  task automatic applyStimulus();
    s0_req   = (rem[0] > 0) && (pos[0] == 0);
    s0_valid = (rem[0] > 0);
    s0_data  = pat(0, fidx[0], pos[0]);
    s0_last  = (rem[0] > 0) && (pos[0] == len[0] - 1);
    s1_req   = (rem[1] > 0) && (pos[1] == 0);
    s1_valid = (rem[1] > 0);
    s1_data  = pat(1, fidx[1], pos[1]);
    s1_last  = (rem[1] > 0) && (pos[1] == len[1] - 1);
    tx_ready = bp_mode ? (cyc % 2 == 1) : 1'b1;
  endtask

  task automatic advance(input int s);
    pos[s]++;
    if (pos[s] == len[s]) begin
      pos[s] = 0;
      fidx[s]++;
      rem[s]--;
    end
  endtask

  task automatic note_grant(input int s);
    order.push_back(s);
    fb = 0;
    if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
    if (end_cyc >= 0) begin
      if (cyc - end_cyc - 1 < gap_min) gap_min = cyc - end_cyc - 1;
      if (cyc - end_cyc - 1 > gap_max) gap_max = cyc - end_cyc - 1;
    end
  endtask

  // One clock: drive, observe at negedge, advance the source models after the edge
  task automatic tick();
    logic a0, a1, txa, exp_last;
    int s;
    cyc++;
    applyStimulus();
    @(negedge clk);
    a0  = s0_valid & s0_ready;
    a1  = s1_valid & s1_ready;
    txa = tx_valid & tx_ready;
    if (s0_gnt && !pg0) note_grant(0);
    if (s1_gnt && !pg1) note_grant(1);
    pg0 = s0_gnt;
    pg1 = s1_gnt;
    if (s0_ready && !s0_gnt) rdy_err++;
    if (s1_ready && !s1_gnt) rdy_err++;
    if (s0_gnt && s1_gnt) rdy_err++;
    if (bp_mode && s1_gnt && (s1_ready !== tx_ready)) mirror_err++;
    if (tx_abort) begin abort_cnt++; abort_cyc = cyc; end
    if (txa) begin
      if (a0 == a1) data_err++;
      else begin
        s = a1 ? 1 : 0;
        fb++;
        beats++;
        if (tx_data !== pat(s, fidx[s], pos[s])) data_err++;
        exp_last = (pos[s] == len[s] - 1) || (fb == MAXF);
        if (tx_last !== exp_last) data_err++;
        if (tx_last) last_beat_no = fb;
        if (tx_last && (pos[s] != len[s] - 1)) begin trunc_beat = fb; trunc_cyc = cyc; end
      end
    end else if (a0 || a1) drop_beats++;
    if ((a0 && s0_last) || (a1 && s1_last)) end_cyc = cyc;
    @(posedge clk);
    #1;
    if (a0) advance(0);
    if (a1) advance(1);
  endtask

  task automatic run_until_done(input int budget);
    int n;
    n = 0;
    while ((rem[0] > 0 || rem[1] > 0) && n < budget) begin
      tick();
      n++;
    end
    check("frames_done_in_budget", rem[0] + rem[1], 0);
    repeat (IFG + 2) tick();
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_s0_gnt"}, int'(s0_gnt), 0);
    check({tag, "_s1_gnt"}, int'(s1_gnt), 0);
    check({tag, "_tx_valid"}, int'(tx_valid), 0);
    check({tag, "_tx_last"}, int'(tx_last), 0);
    check({tag, "_tx_data"}, int'(tx_data), 0);
    check({tag, "_tx_abort"}, int'(tx_abort), 0);
    check({tag, "_ready"}, int'(s0_ready | s1_ready), 0);
    check({tag, "_frm_cnt0"}, int'(frm_cnt0), 0);
    check({tag, "_frm_cnt1"}, int'(frm_cnt1), 0);
  endtask

  // Watchdog so the run always ends
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, vector table, backpressure, truncation, reset mid-frame
  initial begin
    int eo[4];
    total = 0; passed = 0; cyc = 0;
    bp_mode = 1'b0; pg0 = 1'b0; pg1 = 1'b0;
    for (int i = 0; i < 2; i++) begin len[i] = 1; rem[i] = 0; pos[i] = 0; fidx[i] = 0; end
    reset_stats();

`ifdef AQ_GEMAC_TX_ARB_PRIO_EN
    vecs[0] = '{2, 60, 2, 60, 0, 0, 1, 1, 4, 2, 2};
`else
    vecs[0] = '{2, 60, 2, 60, 0, 1, 0, 1, 4, 2, 2};
`endif
    vecs[1] = '{1, 64, 0, 0, 0, -1, -1, -1, 1, 3, 2};
    vecs[2] = '{0, 0, 1, 10, 1, -1, -1, -1, 1, 3, 3};
    vecs[3] = '{0, 0, 1, 5, 1, -1, -1, -1, 1, 3, 4};
    vecs[4] = '{1, 8, 1, 8, 0, 1, -1, -1, 2, 4, 5};
    vecs[5] = '{0, 0, 1, 1, 1, -1, -1, -1, 1, 4, 6};

    rst_n = 1'b0;
    repeat (3) tick();
    applyStimulus();
    @(negedge clk);
    checkOutput("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) tick();

    for (int v = 0; v < 6; v++) begin
      reset_stats();
      rem[0] = vecs[v].n0; len[0] = (vecs[v].l0 > 0) ? vecs[v].l0 : 1; pos[0] = 0;
      rem[1] = vecs[v].n1; len[1] = (vecs[v].l1 > 0) ? vecs[v].l1 : 1; pos[1] = 0;
      start_cyc = cyc + 1;
      run_until_done(3000);
      eo[0] = vecs[v].o0; eo[1] = vecs[v].o1; eo[2] = vecs[v].o2; eo[3] = vecs[v].o3;
      check($sformatf("v%0d_grant_latency", v), first_gnt_cyc - start_cyc, 1);
      check($sformatf("v%0d_grant_count", v), order.size(), vecs[v].no);
      for (int k = 0; k < vecs[v].no; k++)
        check($sformatf("v%0d_grant_order%0d", v, k), (k < order.size()) ? order[k] : -1, eo[k]);
      check($sformatf("v%0d_frm_cnt0", v), int'(frm_cnt0), vecs[v].c0);
      check($sformatf("v%0d_frm_cnt1", v), int'(frm_cnt1), vecs[v].c1);
      check($sformatf("v%0d_tx_beats", v), beats, vecs[v].n0 * vecs[v].l0 + vecs[v].n1 * vecs[v].l1);
      check($sformatf("v%0d_data_errors", v), data_err, 0);
      check($sformatf("v%0d_ready_errors", v), rdy_err, 0);
      check($sformatf("v%0d_abort_pulses", v), abort_cnt, 0);
      if (vecs[v].no > 1) begin
        check($sformatf("v%0d_gap_min", v), gap_min, IFG);
        check($sformatf("v%0d_gap_max", v), gap_max, IFG);
      end
    end

    // Backpressure: TX_READY toggles every cycle during a 48-byte S1 frame
    reset_stats();
    bp_mode = 1'b1;
    rem[1] = 1; len[1] = 48; pos[1] = 0;
    run_until_done(1000);
    bp_mode = 1'b0;
    check("bp_tx_beats", beats, 48);
    check("bp_last_beat", last_beat_no, 48);
    check("bp_data_errors", data_err, 0);
    check("bp_ready_mirror", mirror_err, 0);
    check("bp_ready_errors", rdy_err, 0);
    check("bp_frm_cnt1", int'(frm_cnt1), 7);

    // Truncation: S0 sends 80 bytes with S1 waiting; 64 beats out, 16 drained, then gap and S1
    reset_stats();
    rem[0] = 1; len[0] = 80; pos[0] = 0;
    rem[1] = 1; len[1] = 4;  pos[1] = 0;
    run_until_done(1000);
    check("trunc_beat", trunc_beat, MAXF);
    check("trunc_abort_pulses", abort_cnt, 1);
    check("trunc_abort_delay", abort_cyc - trunc_cyc, 1);
    check("trunc_drop_beats", drop_beats, 16);
    check("trunc_tx_beats", beats, MAXF + 4);
    check("trunc_first_grant", (order.size() > 0) ? order[0] : -1, 0);
    check("trunc_second_grant", (order.size() > 1) ? order[1] : -1, 1);
    check("trunc_gap", gap_min, IFG);
    check("trunc_frm_cnt0", int'(frm_cnt0), 4);
    check("trunc_frm_cnt1", int'(frm_cnt1), 8);
    check("trunc_data_errors", data_err, 0);

    // Reset mid-frame at beat 20, then S1 must be served first-come with no stale grant
    reset_stats();
    rem[0] = 1; len[0] = 40; pos[0] = 0;
    for (int n = 0; n < 200 && beats < 20; n++) tick();
    check("mid_beats_before_reset", beats, 20);
    rst_n = 1'b0;
    tick();
    applyStimulus();
    @(negedge clk);
    checkOutput("mid_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rem[0] = 0; pos[0] = 0;
    reset_stats();
    rem[1] = 1; len[1] = 6; pos[1] = 0;
    start_cyc = cyc + 1;
    run_until_done(500);
    check("post_reset_latency", first_gnt_cyc - start_cyc, 1);
    check("post_reset_grants", order.size(), 1);
    check("post_reset_grant_src", (order.size() > 0) ? order[0] : -1, 1);
    check("post_reset_beats", beats, 6);
    check("post_reset_frm_cnt0", int'(frm_cnt0), 0);
    check("post_reset_frm_cnt1", int'(frm_cnt1), 1);
    check("post_reset_data_errors", data_err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
